// File: rtl/mul_seq_ctrl_if.sv
// Types and handshake bundle for the Booth radix-4 multiply sequencer.
// Groups the request, multiplier and writeback signals; slave = controller, master = environment.
package mul_seq_pkg;
    typedef enum logic [1:0] {
        MUL_    = 2'd0,
        MULH_   = 2'd1,
        MULHU_  = 2'd2,
        MULHSU_ = 2'd3
    } mul_ops_e;

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } fu_state_e;
endpackage

interface mul_seq_ctrl_if
    import mul_seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) ();
    logic             req_valid_i;
    logic             req_ready_o;
    mul_ops_e         req_op_i;
    logic [XLEN-1:0]  req_rs1_i;
    logic [XLEN-1:0]  req_rs2_i;
    logic [TAG_W-1:0] req_tag_i;

    logic             mul_clk_en_o;
    logic [XLEN-1:0]  mul_multiplier_o;
    logic [XLEN-1:0]  mul_multiplicand_o;
    mul_ops_e         mul_operation_o;
    fu_state_e        mul_fu_state_i;
    logic [XLEN-1:0]  mul_result_i;

    logic             wb_valid_o;
    logic             wb_ready_i;
    logic [XLEN-1:0]  wb_result_o;
    logic [TAG_W-1:0] wb_tag_o;

    modport slave (
        input  req_valid_i, req_op_i, req_rs1_i, req_rs2_i, req_tag_i,
        output req_ready_o,
        output mul_clk_en_o, mul_multiplier_o, mul_multiplicand_o,
        output mul_operation_o,
        input  mul_fu_state_i, mul_result_i,
        output wb_valid_o, wb_result_o, wb_tag_o,
        input  wb_ready_i
    );

    modport master (
        output req_valid_i, req_op_i, req_rs1_i, req_rs2_i, req_tag_i,
        input  req_ready_o,
        input  mul_clk_en_o, mul_multiplier_o, mul_multiplicand_o,
        input  mul_operation_o,
        output mul_fu_state_i, mul_result_i,
        input  wb_valid_o, wb_result_o, wb_tag_o,
        output wb_ready_i
    );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Sequencer for the iterative Booth radix-4 multiplier: accepts one request, gates
// the multiplier clock enable for MUL_CYCLES cycles, then hands result+tag to writeback.
// Ports: clk_i, rst_n_i (async low), flush_i, bus (mul_seq_ctrl_if.slave), busy_o, err_o.
// Optional: define MUL_RESULT_REUSE_EN for a one-entry result cache (HIT state).
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int TAG_W      = 4,
    parameter int MUL_CYCLES = 17
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          flush_i,
    mul_seq_ctrl_if.slave bus,
    output logic          busy_o,
    output logic          err_o
);
    localparam int CNT_W = $clog2(MUL_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_CYCLES - 1);

`ifdef MUL_RESULT_REUSE_EN
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, HIT} state_e;
`else
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
`endif

    state_e           r_state;
    state_e           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_rs1;
    logic [XLEN-1:0]  r_rs2;
    mul_ops_e         r_op;
    logic [TAG_W-1:0] r_tag;
    logic             r_err;

    logic             w_ready;
    logic             w_en;
    logic             w_wbv;
    logic [XLEN-1:0]  w_wb_result;
    logic             w_accept;
    logic             w_wb_hs;
    logic             w_hit;
    logic             w_err;

`ifdef MUL_RESULT_REUSE_EN
    logic             r_c_valid;
    logic [XLEN-1:0]  r_c_rs1;
    logic [XLEN-1:0]  r_c_rs2;
    mul_ops_e         r_c_op;
    logic [XLEN-1:0]  r_c_result;

    assign w_hit = r_c_valid
                && (r_c_rs1 == bus.req_rs1_i)
                && (r_c_rs2 == bus.req_rs2_i)
                && (r_c_op == bus.req_op_i);
`else
    assign w_hit = 1'b0;
`endif

    always_comb begin
        w_next      = r_state;
        w_ready     = 1'b0;
        w_en        = 1'b0;
        w_wbv       = 1'b0;
        w_wb_result = bus.mul_result_i;
        unique case (r_state)
            IDLE: begin
                w_ready = ~flush_i;
                if (bus.req_valid_i && w_ready) begin
                    w_next = w_hit ? state_e'(1) : RUN;
`ifdef MUL_RESULT_REUSE_EN
                    if (w_hit) w_next = HIT;
`else
                    w_next = RUN;
`endif
                end
            end
            RUN: begin
                w_en = 1'b1;
                // A flush on the final enabled cycle already leaves the
                // multiplier counter at 0, so no drain is needed.
                if (r_cnt == LAST) w_next = flush_i ? IDLE : DONE;
                else if (flush_i) w_next = DRAIN;
            end
            DRAIN: begin
                w_en = 1'b1;
                if (r_cnt == LAST) w_next = IDLE;
            end
            DONE: begin
                w_wbv = ~flush_i;
                if (flush_i || bus.wb_ready_i) w_next = IDLE;
            end
`ifdef MUL_RESULT_REUSE_EN
            HIT: begin
                w_wbv       = ~flush_i;
                w_wb_result = r_c_result;
                if (flush_i || bus.wb_ready_i) w_next = IDLE;
            end
`endif
            default: w_next = IDLE;
        endcase
    end

    assign w_accept = (r_state == IDLE) && bus.req_valid_i && ~flush_i;
    assign w_wb_hs  = w_wbv && bus.wb_ready_i;

    // Multiplier must be idle at rest/completion and busy once past its load cycle.
    always_comb begin
        w_err = 1'b0;
        unique case (r_state)
            IDLE:    w_err = (bus.mul_fu_state_i != FREE);
            DONE:    w_err = (bus.mul_fu_state_i != FREE);
            RUN:     w_err = (bus.mul_fu_state_i == FREE) && (r_cnt != '0);
`ifdef MUL_RESULT_REUSE_EN
            HIT:     w_err = (bus.mul_fu_state_i != FREE);
`endif
            default: w_err = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rs1   <= '0;
            r_rs2   <= '0;
            r_op    <= MUL_;
            r_tag   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cnt <= '0;
                r_rs1 <= bus.req_rs1_i;
                r_rs2 <= bus.req_rs2_i;
                r_op  <= bus.req_op_i;
                r_tag <= bus.req_tag_i;
            end else if (w_en) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_err) r_err <= 1'b1;
        end
    end

`ifdef MUL_RESULT_REUSE_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_c_valid  <= 1'b0;
            r_c_rs1    <= '0;
            r_c_rs2    <= '0;
            r_c_op     <= MUL_;
            r_c_result <= '0;
        end else if (w_wb_hs) begin
            r_c_valid  <= 1'b1;
            r_c_rs1    <= r_rs1;
            r_c_rs2    <= r_rs2;
            r_c_op     <= r_op;
            r_c_result <= w_wb_result;
        end
    end
`endif

    assign bus.req_ready_o        = w_ready;
    assign bus.mul_clk_en_o       = w_en;
    assign bus.mul_multiplier_o   = r_rs1;
    assign bus.mul_multiplicand_o = r_rs2;
    assign bus.mul_operation_o    = r_op;
    assign bus.wb_valid_o         = w_wbv;
    assign bus.wb_result_o        = w_wb_result;
    assign bus.wb_tag_o           = r_tag;
    assign busy_o                 = (r_state != IDLE);
    assign err_o                  = r_err;
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: behavioural multiplier plus cycle-level expectations
// derived from the latency/flush/writeback rules; honours MUL_RESULT_REUSE_EN.
module tb_mul_seq_ctrl;
    import mul_seq_pkg::*;

    localparam int MUL_CYCLES = 17;

    logic clk;
    logic rst_n;
    logic flush;
    logic busy;
    logic err;

    int n_pass  = 0;
    int n_total = 0;

    logic        c_valid;
    logic [31:0] c_a;
    logic [31:0] c_b;
    mul_ops_e    c_op;

    mul_seq_ctrl_if #(.XLEN(32), .TAG_W(4)) bus ();

    mul_seq_ctrl #(
        .XLEN(32),
        .TAG_W(4),
        .MUL_CYCLES(MUL_CYCLES)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .flush_i(flush),
        .bus    (bus),
        .busy_o (busy),
        .err_o  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(mul_ops_e op, logic [31:0] a,
                                            logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        longint      p;
        logic [63:0] pu;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        pu = {32'd0, a} * {32'd0, b};
        case (op)
            MUL_:    begin p = sa * sb; r = p; return r[31:0]; end
            MULH_:   begin p = sa * sb; r = p; return r[63:32]; end
            MULHU_:  return pu[63:32];
            default: begin p = sa * ub; r = p; return r[63:32]; end
        endcase
    endfunction

    // Multiplier model: an internal counter advanced by clk_en, FREE at 0,
    // result captured from the operand/op lines when the count wraps.
    int          m_cnt;
    logic [31:0] m_res;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0;
            m_res <= '0;
        end else if (bus.mul_clk_en_o) begin
            if (m_cnt == MUL_CYCLES - 1) begin
                m_cnt <= 0;
                m_res <= ref_mul(bus.mul_operation_o, bus.mul_multiplier_o,
                                 bus.mul_multiplicand_o);
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end
    assign bus.mul_fu_state_i = (m_cnt == 0) ? FREE : BUSY;
    assign bus.mul_result_i   = m_res;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic do_mul(input mul_ops_e op, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] tag,
                          input int stall, input int flush_in);
        bit          hit;
        bit          flushed;
        int          flush_at;
        int          wbstart;
        int          endc;
        logic [31:0] exp_r;
        bit          e_en;
        bit          e_wbv;
        hit = 1'b0;
`ifdef MUL_RESULT_REUSE_EN
        hit = c_valid && (c_a == a) && (c_b == b) && (c_op == op);
`endif
        exp_r    = ref_mul(op, a, b);
        wbstart  = hit ? 1 : MUL_CYCLES + 1;
        flush_at = flush_in;
        if (flush_at < 0) flush_at = wbstart;
        if (hit && flush_at > 0) flush_at = 1;
        flushed = (flush_at > 0);
        if (!flushed) endc = wbstart + stall + 1;
        else if (flush_at < wbstart) endc = MUL_CYCLES + 1;
        else endc = flush_at + 1;

        @(posedge clk); #1;
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = op;
        bus.req_rs1_i   = a;
        bus.req_rs2_i   = b;
        bus.req_tag_i   = tag;
        flush           = 1'b0;
        bus.wb_ready_i  = 1'($urandom);
        @(negedge clk);
        chk("accept_ready", bus.req_ready_o, 1'b1);

        for (int c = 1; c <= endc; c++) begin
            @(posedge clk); #1;
            bus.req_valid_i = (c < endc) ? 1'($urandom) : 1'b0;
            bus.req_op_i    = mul_ops_e'($urandom_range(0, 3));
            bus.req_rs1_i   = $urandom;
            bus.req_rs2_i   = $urandom;
            bus.req_tag_i   = 4'($urandom);
            flush           = (c == flush_at);
            bus.wb_ready_i  = (c < wbstart) ? 1'($urandom)
                                            : (c >= wbstart + stall);
            @(negedge clk);
            e_en  = !hit && (c <= MUL_CYCLES);
            e_wbv = !flushed && (c >= wbstart) && (c < endc);
            chk($sformatf("clk_en c%0d", c), bus.mul_clk_en_o, e_en);
            chk($sformatf("ready c%0d", c), bus.req_ready_o, c == endc);
            chk($sformatf("busy c%0d", c), busy, c != endc);
            chk($sformatf("wb_valid c%0d", c), bus.wb_valid_o, e_wbv);
            if (c < endc) begin
                chk("op_mcand", {bus.mul_multiplier_o,
                                 bus.mul_multiplicand_o}, {a, b});
                chk("op_oper", bus.mul_operation_o, op);
            end
            if (e_wbv) begin
                chk($sformatf("wb_result c%0d", c), bus.wb_result_o, exp_r);
                chk($sformatf("wb_tag c%0d", c), bus.wb_tag_o, tag);
            end
        end
        chk("err_clear", err, 1'b0);
        if (!flushed) begin
            c_valid = 1'b1;
            c_a     = a;
            c_b     = b;
            c_op    = op;
        end
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        mul_ops_e    rop;
        int          fsel;
        int          fat;

        rst_n           = 1'b0;
        flush           = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.req_op_i    = MUL_;
        bus.req_rs1_i   = '0;
        bus.req_rs2_i   = '0;
        bus.req_tag_i   = '0;
        bus.wb_ready_i  = 1'b0;
        c_valid         = 1'b0;
        c_a             = '0;
        c_b             = '0;
        c_op            = MUL_;

        #12;
        chk("rst_ready", bus.req_ready_o, 1'b1);
        chk("rst_en", bus.mul_clk_en_o, 1'b0);
        chk("rst_wbv", bus.wb_valid_o, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        do_mul(MUL_, 32'd7, 32'hFFFF_FFFD, 4'd3, 0, 0);
        do_mul(MULH_, 32'h8000_0000, 32'h8000_0000, 4'd5, 0, 0);
        do_mul(MUL_, 32'd100, 32'd200, 4'd1, 5, 0);
        do_mul(MUL_, 32'd1, 32'd2, 4'd2, 0, 5);
        do_mul(MUL_, 32'd6, 32'd7, 4'd4, 0, 0);
        do_mul(MULHU_, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6, 0, -1);
        do_mul(MULHSU_, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd7, 1, 17);

        @(posedge clk); #1;
        bus.req_valid_i = 1'b1;
        flush           = 1'b1;
        @(negedge clk);
        chk("idle_flush_ready", bus.req_ready_o, 1'b0);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        flush           = 1'b0;
        @(negedge clk);
        chk("idle_flush_busy", busy, 1'b0);

        @(posedge clk); #1;
        bus.req_valid_i = 1'b1;
        bus.req_op_i    = MUL_;
        bus.req_rs1_i   = 32'd11;
        bus.req_rs2_i   = 32'd13;
        bus.wb_ready_i  = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            bus.req_valid_i = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_en", bus.mul_clk_en_o, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_wbv", bus.wb_valid_o, 1'b0);
        chk("arst_ready", bus.req_ready_o, 1'b1);
        c_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_mul(MUL_, 32'd3, 32'd5, 4'd8, 0, 0);

        do_mul(MUL_, 32'd5, 32'd9, 4'd9, 0, 0);
        do_mul(MUL_, 32'd5, 32'd9, 4'd10, 0, 0);
        do_mul(MUL_, 32'd5, 32'd9, 4'd11, 2, -1);
        do_mul(MUL_, 32'd5, 32'd9, 4'd12, 1, 0);

        ra  = $urandom;
        rb  = $urandom;
        rop = MUL_;
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                ra  = $urandom;
                rb  = $urandom;
                rop = mul_ops_e'($urandom_range(0, 3));
            end
            fsel = $urandom_range(0, 5);
            fat  = (fsel == 0) ? $urandom_range(1, MUL_CYCLES)
                 : (fsel == 1) ? -1 : 0;
            do_mul(rop, ra, rb, 4'($urandom), $urandom_range(0, 3), fat);
        end

        @(negedge clk);
        chk("final_err", err, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Sequencing controller for the iterative Booth radix-4 multiplication unit.
- Accepts one M-extension multiply request at a time from the issue stage using a valid/ready handshake.
- Holds operands and operation stable for the multiplier, gates its clock enable for exactly the iteration window, and presents the result and tag to writeback with backpressure.
- Handles pipeline flush without corrupting the multiplier's internal iteration counter.

Parameters:
- XLEN, 32, operand/result width.
- TAG_W, 4, instruction tag width.
- MUL_CYCLES, 17, enabled cycles per multiply: 1 load + 16 Booth iterations.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset; also drives the multiplier's rst_n_i
- req_valid_i  in  1  request valid
- req_ready_o  out  1  controller can accept
- req_op_i  in  mul_ops_e  MUL_/MULH_/MULHU_/MULHSU_
- req_rs1_i  in  XLEN  operand 1, mapped to multiplier
- req_rs2_i  in  XLEN  operand 2, mapped to multiplicand
- req_tag_i  in  TAG_W  instruction tag
- flush_i  in  1  kill in-flight and pending request
- mul_clk_en_o  out  1  multiplier clk_en_i
- mul_multiplier_o  out  XLEN  multiplier_i
- mul_multiplicand_o  out  XLEN  multiplicand_i
- mul_operation_o  out  mul_ops_e  operation_i
- mul_fu_state_i  in  fu_state_e  multiplier FREE/BUSY
- mul_result_i  in  XLEN  multiplier result_o
- wb_valid_o  out  1  result valid
- wb_ready_i  in  1  writeback accepts
- wb_result_o  out  XLEN  result
- wb_tag_o  out  TAG_W  tag of result
- busy_o  out  1  state != IDLE
- err_o  out  1  sticky sequencing error

Behaviour:
Reset and interface:
- Single clock clk_i; reset rst_n_i is asynchronous, active-low.
- On reset all registers clear: state=IDLE, cnt=0, operand/op/tag registers 0, err_o=0, cache invalid.
- Outputs during reset: req_ready_o=1, mul_clk_en_o=0, wb_valid_o=0, busy_o=0.

State IDLE:
- req_ready_o = ~flush_i; mul_clk_en_o=0.
- On req_valid_i & req_ready_o: latch rs1, rs2, op, tag; cnt<=0; go to RUN.

State RUN:
- mul_clk_en_o=1; cnt increments each cycle.
- When cnt==MUL_CYCLES-1: go to DONE.
- If flush_i is high in any RUN cycle: go to DRAIN and keep cnt.

State DRAIN:
- mul_clk_en_o=1 until cnt==MUL_CYCLES-1, then go to IDLE. No writeback.
- Purpose: returns the multiplier counter to 0 so it is FREE for the next request.

State DONE:
- mul_clk_en_o=0.
- wb_valid_o = ~flush_i; wb_result_o = mul_result_i; wb_tag_o = latched tag.
- On wb_valid_o & wb_ready_i: go to IDLE.
- If flush_i: go to IDLE with no handshake.

Operand and output rules:
- mul_multiplier_o, mul_multiplicand_o and mul_operation_o always drive the latched registers. They are stable from the cycle after accept until leaving DONE. This is mandatory because the multiplier output mux and MULHSU sign select read them combinationally.
- wb_result_o and wb_tag_o are held stable while wb_valid_o=1 and wb_ready_i=0.

Latency and throughput:
- Request accepted in cycle 0 -> mul_clk_en_o high in cycles 1..17 -> wb_valid_o in cycle 18.
- Throughput is one request per MUL_CYCLES+2 cycles minimum. No overlap: req_ready_o=0 outside IDLE.

Error detection:
- err_o is set (sticky until reset) if mul_fu_state_i != FREE in DONE or IDLE, or if mul_fu_state_i == FREE in RUN while cnt != 0.

Reset mid-operation:
- Controller and multiplier both clear; no writeback is produced.

Simultaneous events:
- flush_i together with req_valid_i in IDLE: not accepted.
- flush_i together with wb_ready_i in DONE: flush wins and no handshake occurs.

Optional Feature:
MUL_RESULT_REUSE_EN
- Defined:
  - One-entry cache holding {valid, rs1, rs2, op, result}, written on every completed writeback handshake and invalidated only by reset.
  - In IDLE, an accepted request whose rs1, rs2 and op all match a valid entry goes to state HIT instead of RUN; mul_clk_en_o stays 0.
  - HIT behaves as DONE but wb_result_o comes from the cache, so wb_valid_o appears in cycle 1.
  - Flush in HIT is handled as in DONE.
- Undefined: no cache and no HIT state; every request runs MUL_CYCLES cycles.

Test Plan:
- MUL_ 7 × 0xFFFFFFFD, tag 3 -> mul_clk_en_o high cycles 1-17; wb_valid_o cycle 18, wb_result_o=0xFFFFFFEB, wb_tag_o=3, err_o=0.
- MULH_ 0x80000000 × 0x80000000 -> wb_result_o=0x40000000 in cycle 18; req_ready_o=0 throughout cycles 1-18.
- MUL_ 100 × 200 with wb_ready_i low cycles 18-22 -> wb_valid_o=1 and wb_result_o=20000 held stable with mul_clk_en_o=0; IDLE in cycle 24 after handshake in cycle 23.
- flush_i pulse in cycle 5 of a MUL_ -> mul_clk_en_o stays high through cycle 17, no wb_valid_o, req_ready_o=1 in cycle 18; next MUL_ 6 × 7 -> 42, err_o=0.
- rst_n_i low asynchronously in cycle 9 -> mul_clk_en_o and busy_o drop immediately; after release, MUL_ 3 × 5 -> 15 at accept+18.
- Two back-to-back MUL_ 5 × 9 -> first result 45 at accept+18; second result 45 at accept+1 with MUL_RESULT_REUSE_EN, at accept+18 without it.
